// File: rtl/spi_master_scheduler_pkg.sv
//============================================================================
// Module      : spi_sched_pkg
// Description : Shared types and width helpers for the SPI master scheduler.
//               Holds the transfer state encoding and the helper used to
//               size the SCLK toggle counter.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

package spi_sched_pkg;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Width of a counter that must hold 0..2*dw SCLK toggles
    function automatic int tog_width(input int dw);
        return $clog2(2 * dw + 1);
    endfunction

    // Width of a requester index (at least one bit)
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_scheduler_arbiter.sv
//============================================================================
// Module      : spi_rr_arbiter
// Description : Round-robin arbiter. Combinational one-hot grant to the
//               first requester after the pointer (wrapping); the pointer
//               moves to the winner when i_advance is strobed.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_en            - grant enable (grant forced to 0 when low)
//               i_advance       - pointer update strobe (handshake)
//               i_req           - per-requester request
//               o_gnt, o_gnt_id - one-hot grant and its index
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module spi_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_advance,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_id
);

    localparam logic [ID_W:0] c_num = (ID_W + 1)'(NUM_REQ);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W:0]   w_idx;
    logic            w_found;

    // Search starts one past the pointer so the last winner has lowest priority
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = {1'b0, r_ptr} + (ID_W + 1)'(off);
            if (w_idx >= c_num) begin
                w_idx = w_idx - c_num;
            end
            if (i_en && !w_found && i_req[w_idx[ID_W-1:0]]) begin
                o_gnt[w_idx[ID_W-1:0]] = 1'b1;
                o_gnt_id               = w_idx[ID_W-1:0];
                w_found                = 1'b1;
            end
        end
    end

    // Reset to the last index so requester 0 is served first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (i_advance) begin
            r_ptr <= o_gnt_id;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master_scheduler.sv
//============================================================================
// Module      : spi_master_scheduler
// Description : Shares one SPI bus between NUM_REQ requesters. Round-robin
//               arbitration, then a full-duplex MSB-first transfer in any
//               CPOL/CPHA mode with SCLK half-period H = baud_div+1 pclk.
// Ports       : pclk, areset           - clock, synchronous active-high reset
//               req_valid/ready/data   - per-requester request handshake
//               cpol, cpha, baud_div   - bus config, captured at grant
//               rsp_valid/id/data      - completion pulse and received word
//               busy                   - transfer in progress
//               sclk, cs_n, mosi, miso - SPI bus
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module spi_master_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy,
    output logic                          sclk,
    output logic [NUM_REQ-1:0]            cs_n,
    output logic                          mosi,
    input  logic                          miso
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TOG_W = tog_width(DATA_WIDTH);

    state_t                r_state;
    logic [DIV_WIDTH:0]    r_cnt;
    logic [TOG_W-1:0]      r_tog;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [ID_W-1:0]       r_id;
    logic                  r_cpol;
    logic                  r_cpha;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_sclk;
    logic [NUM_REQ-1:0]    r_cs_n;
    logic                  r_mosi;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [ID_W-1:0]       w_gnt_id;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_tick;
    logic [TOG_W-1:0]      w_tog_nxt;
    logic                  w_odd;
    logic                  w_last;
    logic                  w_shift_out;
    logic                  w_sample;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (pclk),
        .rst       (areset),
        .i_en      (r_state == IDLE),
        .i_advance (w_hs),
        .i_req     (req_valid),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id)
    );

    // Grant is only ever issued to a valid requester, so any grant is a handshake
    assign w_hs      = |w_gnt;
    assign req_ready = w_gnt;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Counter runs 0..baud_div, so one extra bit is never needed for overflow
    assign w_tick    = (r_cnt == {1'b0, r_div});
    assign w_tog_nxt = r_tog + TOG_W'(1);
    assign w_odd     = w_tog_nxt[0];
    assign w_last    = (w_tog_nxt == TOG_W'(2 * DATA_WIDTH));

    // CPHA=0 drives on trailing edges (MSB already out at grant), samples on
    // leading; CPHA=1 drives on leading edges, samples on trailing.
    assign w_shift_out = r_cpha ? w_odd : (!w_odd && !w_last);
    assign w_sample    = r_cpha ? !w_odd : w_odd;

    always_ff @(posedge pclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tog       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_id        <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_div       <= '0;
            r_sclk      <= 1'b0;
            r_cs_n      <= '1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= cpol;
                    if (w_hs) begin
                        r_id   <= w_gnt_id;
                        r_cpol <= cpol;
                        r_cpha <= cpha;
                        r_div  <= baud_div;
                        r_cs_n <= ~w_gnt;
                        r_cnt  <= '0;
                        r_tog  <= '0;
                        r_rx   <= '0;
                        if (cpha) begin
                            r_tx <= w_sel_data;
                        end else begin
                            r_tx   <= w_sel_data << 1;
                            r_mosi <= w_sel_data[DATA_WIDTH-1];
                        end
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_cnt <= r_cnt + (DIV_WIDTH + 1)'(1);
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        r_tog  <= w_tog_nxt;
                        if (w_shift_out) begin
                            r_mosi <= r_tx[DATA_WIDTH-1];
                            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (w_sample) begin
                            r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
                        end
                        if (w_last) begin
                            r_state <= HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + (DIV_WIDTH + 1)'(1);
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_cnt       <= '0;
                        r_cs_n      <= '1;
                        r_mosi      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_data  <= r_rx;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + (DIV_WIDTH + 1)'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign sclk      = r_sclk;
    assign cs_n      = r_cs_n;
    assign mosi      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_scheduler.sv
//============================================================================
// Module      : tb_spi_master_scheduler
// Description : Directed bench for spi_master_scheduler with an inline SPI
//               slave model driven cycle by cycle from the stimulus thread.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_spi_master_scheduler;

    localparam int NUM_REQ = 2;
    localparam int DW      = 8;
    localparam int DIVW    = 8;

    logic                   pclk = 1'b0;
    logic                   areset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic                   cpol;
    logic                   cpha;
    logic [DIVW-1:0]        baud_div;
    logic                   rsp_valid;
    logic [0:0]             rsp_id;
    logic [DW-1:0]          rsp_data;
    logic                   busy;
    logic                   sclk;
    logic [NUM_REQ-1:0]     cs_n;
    logic                   mosi;
    logic                   miso;

    spi_master_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .pclk      (pclk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .cpol      (cpol),
        .cpha      (cpha),
        .baud_div  (baud_div),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    // observation state
    int  cyc = 0;
    int  hs_total = 0, hs_cycle = 0;
    int  grant_log[$];
    int  rsp_log[$];
    int  rsp_cnt = 0, rsp_cyc = 0;
    int  cs_low = 0, gap = 0, min_gap = 9999;
    int  overlap_err = 0, bad_mosi = 0;
    int  edge_cnt = 0, last_edge = -1, hp_min = 9999, hp_max = 0;
    bit  seen_prev = 1'b0;
    logic prev_cs_act = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic cs_act, sclk_chg, lead;

    // slave model
    logic          s_cpol = 1'b0, s_cpha = 1'b0;
    logic [DW-1:0] s_word = '0, s_tx = '0, s_rx = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One pclk cycle: sample the handshake before the edge, then observe
    // the bus after it and play the slave.
    task automatic step();
        #1;
        if ((req_valid & req_ready) != '0) begin
            hs_total++;
            hs_cycle = cyc;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) grant_log.push_back(i);
            end
        end
        @(negedge pclk);
        cyc++;
        cs_act   = (cs_n != {NUM_REQ{1'b1}});
        sclk_chg = cs_act && prev_cs_act && (sclk != prev_sclk);
        lead     = (sclk != s_cpol);
        if ($countones(~cs_n) > 1) overlap_err++;
        if (cs_act && prev_cs_act && (mosi !== prev_mosi) && !(sclk_chg && (lead == s_cpha)))
            bad_mosi++;
        if (cs_act && !prev_cs_act) begin
            if (seen_prev && gap < min_gap) min_gap = gap;
            gap       = 0;
            cs_low    = 0;
            s_tx      = s_word;
            s_rx      = '0;
            edge_cnt  = 0;
            last_edge = -1;
            hp_min    = 9999;
            hp_max    = 0;
            if (!s_cpha) begin
                miso = s_tx[DW-1];
                s_tx = s_tx << 1;
            end
        end else if (sclk_chg) begin
            edge_cnt++;
            if (last_edge >= 0) begin
                if (cyc - last_edge < hp_min) hp_min = cyc - last_edge;
                if (cyc - last_edge > hp_max) hp_max = cyc - last_edge;
            end
            last_edge = cyc;
            if (lead == s_cpha) begin
                miso = s_tx[DW-1];
                s_tx = s_tx << 1;
            end else begin
                s_rx = {s_rx[DW-2:0], mosi};
            end
        end
        if (!cs_act && prev_cs_act) begin
            seen_prev = 1'b1;
            gap       = 0;
        end
        if (!cs_act) gap++;
        if (cs_act) cs_low++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_log.push_back(int'(rsp_id));
        end
        prev_cs_act = cs_act;
        prev_sclk   = sclk;
        prev_mosi   = mosi;
    endtask

    // Raise a request, wait for its handshake, then drop it
    task automatic request(input logic [NUM_REQ-1:0] mask, input string tag);
        int hs0;
        hs0 = hs_total;
        req_valid = mask;
        for (int n = 0; n < 40 && hs_total == hs0; n++) step();
        req_valid = '0;
        check({tag, "_handshake"}, 32'(hs_total - hs0), 32'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget, input string tag);
        for (int n = 0; n < budget && rsp_cnt < target; n++) step();
        check({tag, "_rsp_count"}, 32'(rsp_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, r0;
        areset    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        baud_div  = '0;
        miso      = 1'b0;
        repeat (3) step();

        // ---- reset state ----
        check("rst_cs_n",      32'(cs_n),      32'h3);
        check("rst_sclk",      32'(sclk),      32'h0);
        check("rst_mosi",      32'(mosi),      32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        check("rst_rsp_data",  32'(rsp_data),  32'h0);
        areset = 1'b0;
        step();

        // ---- mode 0, H=1: req 0 sends A5, slave returns 3C ----
        s_cpol = 1'b0; s_cpha = 1'b0; s_word = 8'h3C;
        req_data = {8'h00, 8'hA5};
        request(2'b01, "t1");
        check("t1_grant_id", 32'(grant_log[grant_log.size()-1]), 32'd0);
        check("t1_busy", 32'(busy), 32'h1);
        wait_rsp(1, 60, "t1");
        check("t1_latency",  32'(rsp_cyc - hs_cycle), 32'd19);
        check("t1_cs_low",   32'(cs_low), 32'd18);
        check("t1_rsp_id",   32'(rsp_id), 32'h0);
        check("t1_rsp_data", 32'(rsp_data), 32'h3C);
        check("t1_mosi_seq", 32'(s_rx), 32'hA5);
        check("t1_edges",    32'(edge_cnt), 32'd16);
        step();
        check("t1_pulse",     32'(rsp_valid), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_hold_data", 32'(rsp_data), 32'h3C);

        // ---- mode 3, H=3: req 1 sends 5A, slave returns 96 ----
        cpol = 1'b1; cpha = 1'b1; baud_div = 8'd2;
        s_cpol = 1'b1; s_cpha = 1'b1; s_word = 8'h96;
        req_data = {8'h5A, 8'h00};
        bad_mosi = 0;
        step(); step();
        check("t2_sclk_idle", 32'(sclk), 32'h1);
        request(2'b10, "t2");
        check("t2_grant_id", 32'(grant_log[grant_log.size()-1]), 32'd1);
        cpol = 1'b0; cpha = 1'b0; baud_div = 8'd0;   // must be ignored mid-transfer
        wait_rsp(2, 120, "t2");
        check("t2_latency",  32'(rsp_cyc - hs_cycle), 32'd55);
        check("t2_hp_min",   32'(hp_min), 32'd3);
        check("t2_hp_max",   32'(hp_max), 32'd3);
        check("t2_edges",    32'(edge_cnt), 32'd16);
        check("t2_mosi_edge", 32'(bad_mosi), 32'd0);
        check("t2_rsp_id",   32'(rsp_id), 32'h1);
        check("t2_rsp_data", 32'(rsp_data), 32'h96);
        check("t2_mosi_seq", 32'(s_rx), 32'h5A);

        // ---- both requesters held for 4 transfers, mode 0, H=1 ----
        cpol = 1'b0; cpha = 1'b0; baud_div = 8'd0;
        s_cpol = 1'b0; s_cpha = 1'b0; s_word = 8'hC3;
        req_data = {8'h22, 8'h11};
        step();
        g0 = grant_log.size(); r0 = rsp_cnt;
        seen_prev = 1'b0; min_gap = 9999; overlap_err = 0; bad_mosi = 0;
        req_valid = 2'b11;
        for (int n = 0; n < 200 && (hs_total - g0) < 4; n++) step();
        req_valid = '0;
        check("t3_handshakes", 32'(hs_total - g0), 32'd4);
        wait_rsp(r0 + 4, 60, "t3");
        check("t3_grant0", 32'(grant_log[g0]),   32'd0);
        check("t3_grant1", 32'(grant_log[g0+1]), 32'd1);
        check("t3_grant2", 32'(grant_log[g0+2]), 32'd0);
        check("t3_grant3", 32'(grant_log[g0+3]), 32'd1);
        check("t3_cs_overlap", 32'(overlap_err), 32'd0);
        check("t3_cs_gap",     32'(min_gap), 32'd2);
        check("t3_mosi_edge",  32'(bad_mosi), 32'd0);
        check("t3_last_id",    32'(rsp_id), 32'h1);
        check("t3_last_data",  32'(rsp_data), 32'hC3);
        check("t3_last_mosi",  32'(s_rx), 32'h22);

        // ---- mode 1, requester 1 only, back to back ----
        cpol = 1'b0; cpha = 1'b1;
        s_cpol = 1'b0; s_cpha = 1'b1; s_word = 8'h81;
        req_data = {8'h3E, 8'h00};
        step();
        r0 = rsp_cnt; g0 = grant_log.size(); bad_mosi = 0;
        req_valid = 2'b10;
        for (int n = 0; n < 200 && (hs_total - g0) < 3; n++) step();
        req_valid = '0;
        check("t4_handshakes", 32'(hs_total - g0), 32'd3);
        wait_rsp(r0 + 3, 60, "t4");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_rsp_id%0d", i), 32'(rsp_log[r0+i]), 32'd1);
        end
        check("t4_rsp_data",  32'(rsp_data), 32'h81);
        check("t4_mosi_seq",  32'(s_rx), 32'h3E);
        check("t4_mosi_edge", 32'(bad_mosi), 32'd0);

        // ---- reset in the middle of SHIFT ----
        cpol = 1'b0; cpha = 1'b0;
        s_cpol = 1'b0; s_cpha = 1'b0; s_word = 8'hF0;
        req_data = {8'h00, 8'h69};
        step();
        request(2'b01, "t5a");
        for (int n = 0; n < 40 && edge_cnt < 5; n++) step();
        check("t5_at_toggle5", 32'(edge_cnt), 32'd5);
        check("t5_sclk_high",  32'(sclk), 32'h1);
        r0 = rsp_cnt;
        areset = 1'b1;
        step();
        check("t5_rst_cs_n",  32'(cs_n), 32'h3);
        check("t5_rst_sclk",  32'(sclk), 32'h0);
        check("t5_rst_busy",  32'(busy), 32'h0);
        check("t5_rst_valid", 32'(rsp_valid), 32'h0);
        areset = 1'b0;
        repeat (3) step();
        check("t5_no_rsp", 32'(rsp_cnt), 32'(r0));
        request(2'b01, "t5b");
        wait_rsp(r0 + 1, 60, "t5");
        check("t5_latency",  32'(rsp_cyc - hs_cycle), 32'd19);
        check("t5_rsp_id",   32'(rsp_id), 32'h0);
        check("t5_rsp_data", 32'(rsp_data), 32'hF0);
        check("t5_mosi_seq", 32'(s_rx), 32'h69);

        // ---- cpol flips mid-transfer, H=2 ----
        cpol = 1'b0; cpha = 1'b0; baud_div = 8'd1;
        s_cpol = 1'b0; s_cpha = 1'b0; s_word = 8'h5C;
        req_data = {8'hB7, 8'h00};
        step();
        r0 = rsp_cnt;
        request(2'b10, "t6");
        repeat (10) step();
        cpol = 1'b1;
        wait_rsp(r0 + 1, 80, "t6");
        check("t6_latency",   32'(rsp_cyc - hs_cycle), 32'd37);
        check("t6_done_sclk", 32'(sclk), 32'h0);
        check("t6_rsp_data",  32'(rsp_data), 32'h5C);
        check("t6_mosi_seq",  32'(s_rx), 32'hB7);
        step();
        check("t6_idle_busy",  32'(busy), 32'h0);
        check("t6_idle1_sclk", 32'(sclk), 32'h0);
        step();
        check("t6_idle2_sclk", 32'(sclk), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
